led_cube_voxel_sink: RTL and testbench
======================================

Name: led_cube_voxel_sink

Overview:
- Receiving end of the voxel-write interface that animation blocks drive (enable, X/Y/Z coordinates, colour).
- Stores an 8x8x8 on/off voxel image: 8 layers (Y) of 64 bits each.
- Continuously scans the image out to the cube hardware through a serial shift-register chain plus one-hot layer enables.
- Sits between all animation generators (countdown, effects) and the physical LED cube pins.

Parameters:
- CLK_DIV, 2: system cycles per ser_clk half-period; legal range 1..255.
- DWELL, 4: cycles a layer stays lit with the serial bus idle before the next layer's shift starts.
- COLOR_W, 4: width of wr_color.

Ports:
- clk  in  1  system clock.
- resetn  in  1  asynchronous active-low reset.
- wr_en  in  1  voxel write strobe, one write per cycle.
- wr_x  in  4  column X.
- wr_y  in  4  layer Y.
- wr_z  in  4  row Z.
- wr_color  in  COLOR_W  nonzero sets the voxel; zero clears it.
- clear  in  1  clears the whole image in one cycle.
- wr_err  out  1  one-cycle pulse: rejected out-of-range write.
- ser_data  out  1  serial column data.
- ser_clk  out  1  shift clock to the cube shift registers.
- ser_latch  out  1  one-cycle latch pulse.
- layer_en  out  8  one-hot layer drive; bit n lights layer Y=n.
- frame_done  out  1  one-cycle pulse after layer 7 is latched.

Behaviour:
- Clock and reset: one clock, clk. Reset resetn is asynchronous, active-low.
- Reset values: image all zero; layer counter 0; state SHIFT at bit 63; all outputs 0.
- Write path:
  - A write is accepted when wr_en=1 and wr_x, wr_y, wr_z are all <8.
  - Bit index = wr_z*8 + wr_x in layer wr_y.
  - The bit updates at the next edge.
  - Any coordinate >=8: image unchanged; wr_err=1 on the next cycle.
- clear:
  - Zeroes all 512 bits at the next edge.
  - clear and wr_en in the same cycle: clear wins, the write is dropped, and wr_err is not raised.
- Scan FSM states: SHIFT -> BLANK -> LATCH -> DWELL -> SHIFT.
- SHIFT:
  - On entry, the current layer's 64 bits are copied into a shadow shift register.
  - Writes during a shift affect only later passes.
  - Bits go out MSB first: bit 63 (z=7, x=7) down to bit 0.
  - Per bit: ser_data is stable, ser_clk is low for CLK_DIV cycles, then high for CLK_DIV cycles.
  - The cube samples on the ser_clk rising edge.
  - SHIFT lasts 64*2*CLK_DIV cycles.
  - layer_en keeps showing the previous layer during SHIFT.
- BLANK: 1 cycle; layer_en=0, ser_clk=0.
- LATCH: 1 cycle; ser_latch=1, layer_en=0.
- DWELL:
  - layer_en = onehot(layer) for DWELL cycles; ser_clk=0; ser_data=0.
  - layer_en stays asserted into the following SHIFT.
- Layer advance and frame timing:
  - Leaving DWELL increments the layer counter 0..7, wrapping to 0.
  - frame_done pulses in the first DWELL cycle of layer 7.
  - Layer period = 128*CLK_DIV + 2 + DWELL cycles. At the defaults: 262 per layer, frame 2096.
- Reset mid-scan: asynchronous return to reset values. layer_en drops immediately, so no ghost layer stays lit.

Optional Feature:
- Macro: LED_CUBE_DBUF_EN.
- Defined:
  - Two image banks; writes and clear target the back bank, the scan reads the front bank.
  - Extra input swap (1 bit): a request is held pending until the frame_done cycle, when the banks swap.
  - After a swap the new back bank is a copy of the new front bank.
  - A swap requested in the frame_done cycle itself takes effect at that boundary.
- Undefined:
  - Single bank; the swap port does not exist.
  - Writes become visible on the next SHIFT entry of that layer.

Decomposition:
- led_cube_pkg holds:
  - CUBE_N=8, COORD_W=4, LAYER_BITS=64.
  - A scan-state enum {SHIFT, BLANK, LATCH, DWELL}.
  - A function for bit index = z*8+x.
- Sub-module cube_shift_serializer:
  - Inputs: load, 64-bit word.
  - Outputs: ser_data, ser_clk, done.
  - Contains the CLK_DIV divider and bit counter.
- Parent keeps: image storage, write decode, layer FSM.

Test Plan:
- Reset, then write (x=2, y=0, z=6, color=3) -> in the layer-0 shift of the next pass, ser_data=1 only on serial bit 50 (the 14th bit shifted). Then LATCH, then layer_en=8'h01 for 4 cycles.
- Write (x=8, y=1, z=0) -> wr_err pulses one cycle; a full frame scans all zeros.
- Set voxel (1,3,1), then in the same cycle assert clear and write (0,3,0) -> layer 3 shifts all zeros; no wr_err.
- Free run 2 frames with defaults -> frame_done spacing is exactly 2096 cycles. layer_en sequence is 01,02,...,80,01 with a 2-cycle zero gap before each change.
- Assert resetn=0 mid-SHIFT of layer 5 -> all outputs 0 asynchronously. After release, scanning restarts at layer 0, bit 63.
- LED_CUBE_DBUF_EN: write (3,3,3) and pulse swap mid-frame -> the voxel is absent until frame_done, present in the next frame.

Source files
------------

// File: rtl/led_cube_pkg.sv
// Shared constants, scan-state encoding and voxel bit addressing for the LED cube sink.
// Latency: none (declarations only).
// Backpressure: none (declarations only).
package led_cube_pkg;

  localparam int CUBE_N     = 8;
  localparam int COORD_W    = 4;
  localparam int LAYER_BITS = 64;

  typedef enum logic [1:0] {
    ST_SHIFT = 2'd0,
    ST_BLANK = 2'd1,
    ST_LATCH = 2'd2,
    ST_DWELL = 2'd3
  } scan_state_t;

  // Position of voxel (z, x) inside its 64-bit layer word: z*8 + x.
  function automatic logic [5:0] bit_index(input logic [2:0] z, input logic [2:0] x);
    return {z, x};
  endfunction

endpackage

// File: rtl/led_cube_voxel_sink_if.sv
// Voxel-write bus from the animation generators into the cube sink (optional swap with LED_CUBE_DBUF_EN).
// Latency: wr_err returns one cycle after the rejected write.
// Backpressure: none; every cycle may carry one write, the sink always accepts.
interface led_cube_voxel_sink_if #(
  parameter int COLOR_W = 4
) ();

  logic                                wr_en;
  logic [led_cube_pkg::COORD_W-1:0]    wr_x;
  logic [led_cube_pkg::COORD_W-1:0]    wr_y;
  logic [led_cube_pkg::COORD_W-1:0]    wr_z;
  logic [COLOR_W-1:0]                  wr_color;
  logic                                clear;
  logic                                wr_err;
`ifdef LED_CUBE_DBUF_EN
  logic                                swap;
`endif

  modport master (
`ifdef LED_CUBE_DBUF_EN
    output swap,
`endif
    output wr_en, wr_x, wr_y, wr_z, wr_color, clear,
    input  wr_err
  );

  modport slave (
`ifdef LED_CUBE_DBUF_EN
    input  swap,
`endif
    input  wr_en, wr_x, wr_y, wr_z, wr_color, clear,
    output wr_err
  );

endinterface

// File: rtl/led_cube_voxel_sink_serializer.sv
// Shifts one 64-bit layer word out MSB first with a divided ser_clk (low then high, CLK_DIV cycles each).
// Latency: first bit valid the cycle after load; done on the last cycle of bit 0 (128*CLK_DIV cycles).
// Backpressure: none; load is only issued while idle.
module cube_shift_serializer
  import led_cube_pkg::*;
#(
  parameter int CLK_DIV = 2
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  load,
  input  logic [LAYER_BITS-1:0] word,
  output logic                  ser_data,
  output logic                  ser_clk,
  output logic                  done
);

  localparam logic [7:0] DIV_LAST = 8'(CLK_DIV - 1);

  logic [LAYER_BITS-1:0] shreg_q, shreg_d;
  logic [5:0]            bit_q, bit_d;
  logic [7:0]            div_q, div_d;
  logic                  phase_q, phase_d;
  logic                  busy_q, busy_d;
  logic                  div_wrap;

  // Divider, half-period phase and bit countdown; shift the word after each high phase.
  always_comb begin
    shreg_d  = shreg_q;
    bit_d    = bit_q;
    div_d    = div_q;
    phase_d  = phase_q;
    busy_d   = busy_q;
    div_wrap = (div_q == DIV_LAST);
    done     = busy_q && phase_q && div_wrap && (bit_q == 6'd0);
    if (load) begin
      shreg_d = word;
      bit_d   = 6'd63;
      div_d   = '0;
      phase_d = 1'b0;
      busy_d  = 1'b1;
    end else if (busy_q) begin
      if (!div_wrap) begin
        div_d = div_q + 8'd1;
      end else begin
        div_d   = '0;
        phase_d = !phase_q;
        if (phase_q) begin
          shreg_d = {shreg_q[LAYER_BITS-2:0], 1'b0};
          bit_d   = bit_q - 6'd1;
          if (bit_q == 6'd0) busy_d = 1'b0;
        end
      end
    end
  end

  // Reset lands mid-scan-start: busy at bit 63 with an all-zero word (the image is also zero).
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      shreg_q <= '0;
      bit_q   <= 6'd63;
      div_q   <= '0;
      phase_q <= 1'b0;
      busy_q  <= 1'b1;
    end else begin
      shreg_q <= shreg_d;
      bit_q   <= bit_d;
      div_q   <= div_d;
      phase_q <= phase_d;
      busy_q  <= busy_d;
    end
  end

  assign ser_data = busy_q & shreg_q[LAYER_BITS-1];
  assign ser_clk  = busy_q & phase_q;

endmodule

// File: rtl/led_cube_voxel_sink.sv
// 8x8x8 voxel image store plus layer scan-out (SHIFT/BLANK/LATCH/DWELL); LED_CUBE_DBUF_EN adds front/back banks.
// Latency: writes land at the next edge; wr_err one cycle after a rejected write; layer period 128*CLK_DIV+2+DWELL.
// Backpressure: none; one write per cycle always accepted, cube pins free-run.
module led_cube_voxel_sink
  import led_cube_pkg::*;
#(
  parameter int CLK_DIV = 2,
  parameter int DWELL   = 4,
  parameter int COLOR_W = 4
) (
  input  logic                  clk,
  input  logic                  resetn,
  led_cube_voxel_sink_if.slave  vox,
  output logic                  ser_data,
  output logic                  ser_clk,
  output logic                  ser_latch,
  output logic [CUBE_N-1:0]     layer_en,
  output logic                  frame_done
);

  localparam logic [7:0] DWELL_LAST = 8'(DWELL - 1);

  logic [COLOR_W-1:0]                color;
  logic                              in_range, wr_ok, set_val;
  logic [2:0]                        wy;
  logic [5:0]                        widx;
  logic                              wr_err_q, wr_err_d;
  logic [CUBE_N-1:0][LAYER_BITS-1:0] scan_img;

  scan_state_t      state_q, state_d;
  logic [2:0]       layer_q, layer_d, next_layer;
  logic [7:0]       dwell_q, dwell_d;
  logic [CUBE_N-1:0] hold_en_q, hold_en_d, layer_oh;
  logic             ser_load, ser_done;

  assign color    = vox.wr_color;
  assign in_range = (vox.wr_x < COORD_W'(CUBE_N)) && (vox.wr_y < COORD_W'(CUBE_N)) &&
                    (vox.wr_z < COORD_W'(CUBE_N));
  assign wr_ok    = vox.wr_en && !vox.clear && in_range;
  assign set_val  = |color;
  assign wy       = vox.wr_y[2:0];
  assign widx     = bit_index(vox.wr_z[2:0], vox.wr_x[2:0]);
  assign wr_err_d = vox.wr_en && !vox.clear && !in_range;
  assign vox.wr_err = wr_err_q;

`ifdef LED_CUBE_DBUF_EN
  logic [CUBE_N-1:0][LAYER_BITS-1:0] back_q, back_d, front_q, front_d;
  logic                              swap_pend_q, swap_pend_d, swap_fire;

  // Writes/clear hit the back bank; at frame_done a pending swap copies back into front, leaving both equal.
  always_comb begin
    back_d = back_q;
    if (vox.clear) back_d = '0;
    else if (wr_ok) back_d[wy][widx] = set_val;
    swap_fire   = frame_done && (swap_pend_q || vox.swap);
    front_d     = swap_fire ? back_d : front_q;
    swap_pend_d = swap_fire ? 1'b0 : (swap_pend_q || vox.swap);
  end

  // Bank storage and pending swap request.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      back_q      <= '0;
      front_q     <= '0;
      swap_pend_q <= 1'b0;
    end else begin
      back_q      <= back_d;
      front_q     <= front_d;
      swap_pend_q <= swap_pend_d;
    end
  end

  assign scan_img = front_q;
`else
  logic [CUBE_N-1:0][LAYER_BITS-1:0] img_q, img_d;

  // Single bank: clear beats a same-cycle write; the scan picks changes up at its next load.
  always_comb begin
    img_d = img_q;
    if (vox.clear) img_d = '0;
    else if (wr_ok) img_d[wy][widx] = set_val;
  end

  // Image storage.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) img_q <= '0;
    else         img_q <= img_d;
  end

  assign scan_img = img_q;
`endif

  assign next_layer = layer_q + 3'd1;
  assign layer_oh   = CUBE_N'(1) << layer_q;

  // Scan sequencer: the layer counter names the layer being shifted/latched/lit; it advances as DWELL ends.
  always_comb begin
    state_d   = state_q;
    layer_d   = layer_q;
    dwell_d   = dwell_q;
    hold_en_d = hold_en_q;
    ser_load  = 1'b0;
    case (state_q)
      ST_SHIFT: if (ser_done) state_d = ST_BLANK;
      ST_BLANK: state_d = ST_LATCH;
      ST_LATCH: begin
        state_d = ST_DWELL;
        dwell_d = '0;
      end
      ST_DWELL: begin
        hold_en_d = layer_oh;
        if (dwell_q == DWELL_LAST) begin
          state_d  = ST_SHIFT;
          layer_d  = next_layer;
          ser_load = 1'b1;
        end else begin
          dwell_d = dwell_q + 8'd1;
        end
      end
      default: state_d = ST_SHIFT;
    endcase
  end

  // Scan state registers and the write-error pulse.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= ST_SHIFT;
      layer_q   <= '0;
      dwell_q   <= '0;
      hold_en_q <= '0;
      wr_err_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      layer_q   <= layer_d;
      dwell_q   <= dwell_d;
      hold_en_q <= hold_en_d;
      wr_err_q  <= wr_err_d;
    end
  end

  // Layer drive: lit in DWELL, held through the next SHIFT, dark for BLANK/LATCH (and straight after reset).
  always_comb begin
    layer_en = '0;
    case (state_q)
      ST_DWELL: layer_en = layer_oh;
      ST_SHIFT: layer_en = hold_en_q;
      default:  layer_en = '0;
    endcase
  end

  assign ser_latch  = (state_q == ST_LATCH);
  assign frame_done = (state_q == ST_DWELL) && (dwell_q == 8'd0) && (layer_q == 3'd7);

  cube_shift_serializer #(
    .CLK_DIV (CLK_DIV)
  ) u_ser (
    .clk      (clk),
    .resetn   (resetn),
    .load     (ser_load),
    .word     (scan_img[next_layer]),
    .ser_data (ser_data),
    .ser_clk  (ser_clk),
    .done     (ser_done)
  );

endmodule

// File: tb/tb_led_cube_voxel_sink.sv
// Directed bench for led_cube_voxel_sink: stimulus queues expected layer words, error pulses and frame spacing.
// A negedge monitor rebuilds each shifted layer from ser_clk/ser_data and pops the expectations.
module tb_led_cube_voxel_sink;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic       ser_data, ser_clk, ser_latch, frame_done;
  logic [7:0] layer_en;

  led_cube_voxel_sink_if #(.COLOR_W(4)) vox ();

  led_cube_voxel_sink #(
    .CLK_DIV (2),
    .DWELL   (4),
    .COLOR_W (4)
  ) dut (
    .clk        (clk),
    .resetn     (resetn),
    .vox        (vox),
    .ser_data   (ser_data),
    .ser_clk    (ser_clk),
    .ser_latch  (ser_latch),
    .layer_en   (layer_en),
    .frame_done (frame_done)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [63:0] word;
    logic [7:0]  en;
    int          lat_cyc;
  } rec_t;

  rec_t exp_q[$];
  int   err_q[$];
  int   fd_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- monitor ----------------
  logic [63:0] sh_word = '0, lat_word = '0;
  int          rises = 0, lat_rises = 0, lat_cyc = 0, zrun = 0, last_fd = 0;
  bit          prev_sclk = 0, lat_pend = 0, armed = 0;
  rec_t        e;

  always @(negedge clk) begin
    if (!resetn) begin
      sh_word = '0; rises = 0; prev_sclk = 0; lat_pend = 0; armed = 0; zrun = 0;
    end else begin
      if (ser_clk && !prev_sclk) begin
        sh_word = {sh_word[62:0], ser_data};
        rises++;
      end
      prev_sclk = ser_clk;
      if (lat_pend) begin
        lat_pend = 0;
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          chk("layer_word", lat_word, e.word);
          chk("layer_en", {56'd0, layer_en}, {56'd0, e.en});
          chk("bit_count", 64'(lat_rises), 64'd64);
          if (e.lat_cyc != 0) chk("latch_cycle", 64'(lat_cyc), 64'(e.lat_cyc));
        end
      end
      if (ser_latch) begin
        lat_word = sh_word; lat_rises = rises; lat_cyc = cyc; lat_pend = 1;
        sh_word = '0; rises = 0;
      end
      if (layer_en == 8'h00) zrun++;
      else begin
        if (armed && zrun > 0) chk("en_gap", 64'(zrun), 64'd2);
        armed = 1; zrun = 0;
      end
      if (err_q.size() > 0 && err_q[0] < cyc) begin
        checks++; errors++;
        $display("FAIL wr_err_missing: got no pulse expected pulse at cycle %0d", err_q[0]);
        void'(err_q.pop_front());
      end
      if (vox.wr_err) begin
        if (err_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL wr_err_unexpected: got pulse at cycle %0d expected none", cyc);
        end else begin
          chk("wr_err_cycle", 64'(cyc), 64'(err_q.pop_front()));
        end
      end
      if (frame_done) begin
        chk("fd_layer", {56'd0, layer_en}, 64'h80);
        if (fd_q.size() > 0) chk("fd_spacing", 64'(cyc - last_fd), 64'(fd_q.pop_front()));
        last_fd = cyc;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  logic [63:0] fw [8];

  task automatic wr(input logic [3:0] x, input logic [3:0] y, input logic [3:0] z,
                    input logic [3:0] c, input bit clr, input bit exp_err);
    @(negedge clk);
    vox.wr_en = 1'b1; vox.wr_x = x; vox.wr_y = y; vox.wr_z = z;
    vox.wr_color = c; vox.clear = clr;
    if (exp_err) err_q.push_back(cyc + 1);
    @(negedge clk);
    vox.wr_en = 1'b0; vox.clear = 1'b0;
  endtask

  task automatic commit();
`ifdef LED_CUBE_DBUF_EN
    @(negedge clk); vox.swap = 1'b1;
    @(negedge clk); vox.swap = 1'b0;
`endif
  endtask

  task automatic wait_fd();
    int n = 0;
    @(negedge clk);
    while (!frame_done && n < 3000) begin @(negedge clk); n++; end
    if (!frame_done) begin
      checks++; errors++;
      $display("FAIL wait_frame_done: got timeout expected pulse");
    end
    #2;
  endtask

  task automatic push_frame(input logic [63:0] w [8]);
    rec_t r;
    for (int l = 0; l < 8; l++) begin
      r.word = w[l]; r.en = 8'(8'b1 << l); r.lat_cyc = 0;
      exp_q.push_back(r);
    end
  endtask

  task automatic zero_fw();
    for (int i = 0; i < 8; i++) fw[i] = '0;
  endtask

  task automatic drain();
    int n = 0;
    while ((exp_q.size() != 0 || fd_q.size() != 0) && n < 6000) begin @(negedge clk); n++; end
    if (exp_q.size() != 0 || fd_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL drain: got %0d records pending expected 0", exp_q.size());
      exp_q.delete(); fd_q.delete();
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_layer_en"}, {56'd0, layer_en}, 64'd0);
    chk({tag, "_pins"}, {59'd0, ser_data, ser_clk, ser_latch, frame_done, vox.wr_err}, 64'd0);
  endtask

  // ---------------- main sequence ----------------
  initial begin
    int   n, r;
    rec_t rr;
    vox.wr_en = 0; vox.wr_x = 0; vox.wr_y = 0; vox.wr_z = 0; vox.wr_color = 0; vox.clear = 0;
`ifdef LED_CUBE_DBUF_EN
    vox.swap = 0;
`endif
    repeat (3) @(posedge clk);
    #1 chk_idle("reset");
    @(posedge clk); #2 resetn = 1'b1;

    // Voxel (2,0,6) -> layer 0 bit 50; corner (7,7,7) -> layer 7 bit 63.
    wr(4'd2, 4'd0, 4'd6, 4'd3, 1'b0, 1'b0);
    wr(4'd7, 4'd7, 4'd7, 4'd1, 1'b0, 1'b0);
    commit();
    wait_fd();
    zero_fw();
    fw[0] = 64'h0004_0000_0000_0000;
    fw[7] = 64'h8000_0000_0000_0000;
    push_frame(fw);
    drain();

    // Clear with an out-of-range write (no error), then rejected writes on each axis.
    wr(4'd9, 4'd0, 4'd0, 4'd1, 1'b1, 1'b0);
    wr(4'd8, 4'd1, 4'd0, 4'd1, 1'b0, 1'b1);
    wr(4'd0, 4'd0, 4'd15, 4'd1, 1'b0, 1'b1);
    wr(4'd0, 4'd8, 4'd0, 4'd1, 1'b0, 1'b1);
    commit();
    wait_fd();
    zero_fw();
    push_frame(fw);
    drain();

    // Set (1,3,1) then clear plus write (0,3,0) together: layer 3 must come out empty.
    wr(4'd1, 4'd3, 4'd1, 4'd5, 1'b0, 1'b0);
    wr(4'd0, 4'd3, 4'd0, 4'd2, 1'b1, 1'b0);
    commit();
    wait_fd();
    zero_fw();
    push_frame(fw);
    drain();

    // Free run: two frame periods of 2096 cycles and the full 01..80,01 layer sequence.
    wait_fd();
    fd_q.push_back(2096);
    fd_q.push_back(2096);
    zero_fw();
    push_frame(fw);
    push_frame(fw);
    drain();

    // Reset in the middle of layer 5's shift; scan restarts at layer 0, bit 63, image cleared.
    wr(4'd4, 4'd0, 4'd4, 4'd1, 1'b0, 1'b0);
    commit();
    n = 0;
    while (layer_en != 8'h10 && n < 3000) begin @(negedge clk); n++; end
    chk("wait_layer4", {56'd0, layer_en}, 64'h10);
    repeat (100) @(negedge clk);
    #2 resetn = 1'b0;
    #1 chk_idle("async_reset");
    repeat (3) @(posedge clk);
    #2 resetn = 1'b1;
    r = cyc;
    rr.word = '0; rr.en = 8'h01; rr.lat_cyc = r + 257;
    exp_q.push_back(rr);
    rr.en = 8'h02; rr.lat_cyc = r + 257 + 262;
    exp_q.push_back(rr);
    drain();

`ifdef LED_CUBE_DBUF_EN
    // Back-bank write plus mid-frame swap: hidden for one frame, shown after the next frame_done.
    wait_fd();
    zero_fw();
    push_frame(fw);
    fw[3] = 64'h0000_0000_0800_0000;
    push_frame(fw);
    wr(4'd3, 4'd3, 4'd3, 4'd1, 1'b0, 1'b0);
    repeat (300) @(negedge clk);
    vox.swap = 1'b1;
    @(negedge clk);
    vox.swap = 1'b0;
    drain();
`endif

    repeat (4) @(negedge clk);
    chk("err_q_empty", 64'(err_q.size()), 64'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1000000;
    errors++;
    $display("FAIL watchdog: got timeout expected completion");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $fatal(1, "watchdog");
  end

endmodule
